// File: rtl/dcpu_stack.sv
// dcpu_stack: parametrised LIFO used as the data and return stack of the dcpu
// core. Provides a depth counter, full/empty status, sticky overflow/underflow
// flags, a single-cycle replace, and a saturating or circular mode (WRAP).
module dcpu_stack #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 6,
  parameter int WRAP       = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_wr_top,
  input  logic [WIDTH-1:0]      i_dat,
  input  logic                  i_clr_err,
  output logic [WIDTH-1:0]      o_T,
  output logic [WIDTH-1:0]      o_N,
  output logic [DEPTH_LOG2:0]   o_depth,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] p_q, p_d;
  logic [DEPTH_LOG2:0]   d_q, d_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic [DEPTH_LOG2-1:0] p_inc, p_dec, wr_addr;
  logic                  wr_en;
  logic                  ovf_set, unf_set;
  logic                  is_empty, is_full, has_two;

  assign p_inc    = p_q + 1'b1;
  assign p_dec    = p_q - 1'b1;
  assign is_empty = (d_q == '0);
  // d never exceeds DEPTH, so its MSB alone marks the full condition.
  assign is_full  = d_q[DEPTH_LOG2];
  assign has_two  = (d_q > {{DEPTH_LOG2{1'b0}}, 1'b1});

  // Command decode: next pointer, depth, write strobe and error events.
  always_comb begin
    p_d     = p_q;
    d_d     = d_q;
    wr_en   = 1'b0;
    wr_addr = p_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (i_push && i_pop) begin
      // Replace: on an empty stack this creates the single top entry in place.
      wr_en = 1'b1;
      if (is_empty) d_d = {{DEPTH_LOG2{1'b0}}, 1'b1};
    end else if (i_push) begin
      if (is_full) begin
        ovf_set = 1'b1;
        if (WRAP != 0) begin
          // Circular: overwrite the oldest entry, depth stays at DEPTH.
          p_d     = p_inc;
          wr_en   = 1'b1;
          wr_addr = p_inc;
        end
      end else begin
        p_d     = p_inc;
        wr_en   = 1'b1;
        wr_addr = p_inc;
        d_d     = d_q + 1'b1;
      end
    end else if (i_pop) begin
      if (is_empty) begin
        unf_set = 1'b1;
        if (WRAP != 0) p_d = p_dec;
      end else begin
        p_d = p_dec;
        d_d = d_q - 1'b1;
      end
    end else if (i_wr_top) begin
      wr_en = 1'b1;
      if (is_empty) d_d = {{DEPTH_LOG2{1'b0}}, 1'b1};
    end
    // A set event in the same cycle takes priority over a clear.
    ovf_d = ovf_set | (ovf_q & ~i_clr_err);
    unf_d = unf_set | (unf_q & ~i_clr_err);
  end

  // Pointer, depth and sticky flag registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      p_q   <= '1;
      d_q   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      d_q   <= d_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage is not reset; a write landing while reset is held is never
  // visible because depth is forced to 0 and every read is masked by depth.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_addr] <= i_dat;
  end

  // Outputs come from registered state only.
  always_comb begin
    o_T         = is_empty ? '0 : mem_q[p_q];
    o_N         = has_two ? mem_q[p_dec] : '0;
    o_depth     = d_q;
    o_empty     = is_empty;
    o_full      = is_full;
    o_overflow  = ovf_q;
    o_underflow = unf_q;
  end

endmodule

// File: tb/tb_dcpu_stack.sv
// Bench for dcpu_stack: one saturating and one circular instance (DEPTH=4)
// driven with the same commands, each tracked by an array-based stack model.
module tb_dcpu_stack;

  localparam int W  = 16;
  localparam int DL = 2;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push, pop, wr, clr;
  logic [W-1:0]  dat;

  logic [W-1:0]  t_o [2];
  logic [W-1:0]  n_o [2];
  logic [DL:0]   d_o [2];
  logic          e_o [2];
  logic          f_o [2];
  logic          ov_o [2];
  logic          un_o [2];

  int total = 0;
  int bad   = 0;

  // Reference model: arr[k][0] is the bottom of stack k, cnt[k] its depth.
  logic [W-1:0]  arr [2][DP];
  int            cnt [2];
  bit            m_ovf [2];
  bit            m_unf [2];

  typedef struct {
    bit          pu, po, wt, cl;
    logic [15:0] dt;
    logic [15:0] t, n;
    int          d;
    bit          ovf, unf;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  dcpu_stack #(.WIDTH(W), .DEPTH_LOG2(DL), .WRAP(0)) u0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_push(push), .i_pop(pop),
    .i_wr_top(wr), .i_dat(dat), .i_clr_err(clr),
    .o_T(t_o[0]), .o_N(n_o[0]), .o_depth(d_o[0]), .o_empty(e_o[0]),
    .o_full(f_o[0]), .o_overflow(ov_o[0]), .o_underflow(un_o[0]));

  dcpu_stack #(.WIDTH(W), .DEPTH_LOG2(DL), .WRAP(1)) u1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_push(push), .i_pop(pop),
    .i_wr_top(wr), .i_dat(dat), .i_clr_err(clr),
    .o_T(t_o[1]), .o_N(n_o[1]), .o_depth(d_o[1]), .o_empty(e_o[1]),
    .o_full(f_o[1]), .o_overflow(ov_o[1]), .o_underflow(un_o[1]));

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cnt[k]   = 0;
      m_ovf[k] = 1'b0;
      m_unf[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit os, us;
    for (int k = 0; k < 2; k++) begin
      os = 1'b0;
      us = 1'b0;
      if ((push && pop) || (wr && !push && !pop)) begin
        if (cnt[k] == 0) begin
          arr[k][0] = dat;
          cnt[k]    = 1;
        end else begin
          arr[k][cnt[k]-1] = dat;
        end
      end else if (push) begin
        if (cnt[k] == DP) begin
          os = 1'b1;
          if (k == 1) begin
            for (int i = 0; i < DP-1; i++) arr[k][i] = arr[k][i+1];
            arr[k][DP-1] = dat;
          end
        end else begin
          arr[k][cnt[k]] = dat;
          cnt[k]++;
        end
      end else if (pop) begin
        if (cnt[k] == 0) us = 1'b1;
        else cnt[k]--;
      end
      m_ovf[k] = os | (m_ovf[k] & !clr);
      m_unf[k] = us | (m_unf[k] & !clr);
    end
  endtask

  task automatic check_model(input int idx);
    logic [W-1:0] et, en;
    for (int k = 0; k < 2; k++) begin
      et = (cnt[k] > 0) ? arr[k][cnt[k]-1] : '0;
      en = (cnt[k] > 1) ? arr[k][cnt[k]-2] : '0;
      check(k == 0 ? "m0_T" : "m1_T", idx, 32'(t_o[k]), 32'(et));
      check(k == 0 ? "m0_N" : "m1_N", idx, 32'(n_o[k]), 32'(en));
      check(k == 0 ? "m0_depth" : "m1_depth", idx, 32'(d_o[k]), 32'(cnt[k]));
      check(k == 0 ? "m0_empty" : "m1_empty", idx, 32'(e_o[k]), 32'(cnt[k] == 0));
      check(k == 0 ? "m0_full" : "m1_full", idx, 32'(f_o[k]), 32'(cnt[k] == DP));
      check(k == 0 ? "m0_ovf" : "m1_ovf", idx, 32'(ov_o[k]), 32'(m_ovf[k]));
      check(k == 0 ? "m0_unf" : "m1_unf", idx, 32'(un_o[k]), 32'(m_unf[k]));
    end
  endtask

  // Drive one command for one clock, advance the model, sample at negedge.
  task automatic cyc(input bit pu, input bit po, input bit wt, input bit cl,
                     input logic [15:0] dt, input int idx);
    push = pu; pop = po; wr = wt; clr = cl; dat = dt;
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_model(idx);
  endtask

  task automatic add(input bit pu, po, wt, cl, input logic [15:0] dt,
                     input logic [15:0] t, n, input int d, input bit ovf, unf);
    vec_t v;
    v.pu = pu; v.po = po; v.wt = wt; v.cl = cl; v.dt = dt;
    v.t = t; v.n = n; v.d = d; v.ovf = ovf; v.unf = unf;
    tbl.push_back(v);
  endtask

  task automatic chk1(input string name, input int k, input logic [15:0] t,
                      input logic [15:0] n, input int d, input bit ovf);
    check({name, "_T"}, k, 32'(t_o[k]), 32'(t));
    check({name, "_N"}, k, 32'(n_o[k]), 32'(n));
    check({name, "_depth"}, k, 32'(d_o[k]), 32'(d));
    check({name, "_ovf"}, k, 32'(ov_o[k]), 32'(ovf));
  endtask

  initial begin
    rst_n = 1'b0;
    push = 0; pop = 0; wr = 0; clr = 0; dat = '0;
    model_reset();

    // Reset state, checked while reset is still asserted.
    #2;
    for (int k = 0; k < 2; k++) begin
      check("rst_T", k, 32'(t_o[k]), 32'h0);
      check("rst_N", k, 32'(n_o[k]), 32'h0);
      check("rst_depth", k, 32'(d_o[k]), 32'h0);
      check("rst_empty", k, 32'(e_o[k]), 32'h1);
      check("rst_full", k, 32'(f_o[k]), 32'h0);
      check("rst_ovf", k, 32'(ov_o[k]), 32'h0);
      check("rst_unf", k, 32'(un_o[k]), 32'h0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //   pu po wt cl  dat       T        N        d ovf unf   (saturating)
    add(1, 0, 0, 0, 16'h1111, 16'h1111, 16'h0000, 1, 0, 0);
    add(1, 0, 0, 0, 16'h2222, 16'h2222, 16'h1111, 2, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h1111, 16'h0000, 1, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    add(1, 0, 0, 0, 16'h0001, 16'h0001, 16'h0000, 1, 0, 0);
    add(1, 0, 0, 0, 16'h0002, 16'h0002, 16'h0001, 2, 0, 0);
    add(1, 0, 0, 0, 16'h0003, 16'h0003, 16'h0002, 3, 0, 0);
    add(1, 0, 0, 0, 16'h0004, 16'h0004, 16'h0003, 4, 0, 0);
    add(1, 0, 0, 0, 16'h0005, 16'h0004, 16'h0003, 4, 1, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0003, 16'h0002, 3, 1, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0002, 16'h0001, 2, 1, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0001, 16'h0000, 1, 1, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0);
    add(0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
    add(0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
    add(0, 1, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
    add(0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    add(1, 0, 0, 0, 16'hAAAA, 16'hAAAA, 16'h0000, 1, 0, 0);
    add(1, 0, 0, 0, 16'hBBBB, 16'hBBBB, 16'hAAAA, 2, 0, 0);
    add(1, 1, 0, 0, 16'hCCCC, 16'hCCCC, 16'hAAAA, 2, 0, 0);
    add(0, 0, 1, 0, 16'h1234, 16'h1234, 16'hAAAA, 2, 0, 0);
    add(0, 1, 1, 0, 16'h5555, 16'hAAAA, 16'h0000, 1, 0, 0);
    add(1, 1, 0, 0, 16'h7777, 16'h7777, 16'h0000, 1, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    add(1, 1, 0, 0, 16'h9999, 16'h9999, 16'h0000, 1, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    add(0, 0, 1, 0, 16'h0ABC, 16'h0ABC, 16'h0000, 1, 0, 0);
    add(1, 0, 1, 0, 16'h0DEF, 16'h0DEF, 16'h0ABC, 2, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0ABC, 16'h0000, 1, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].pu, tbl[i].po, tbl[i].wt, tbl[i].cl, tbl[i].dt, i);
      check("tbl_T", i, 32'(t_o[0]), 32'(tbl[i].t));
      check("tbl_N", i, 32'(n_o[0]), 32'(tbl[i].n));
      check("tbl_depth", i, 32'(d_o[0]), 32'(tbl[i].d));
      check("tbl_empty", i, 32'(e_o[0]), 32'(tbl[i].d == 0));
      check("tbl_full", i, 32'(f_o[0]), 32'(tbl[i].d == DP));
      check("tbl_ovf", i, 32'(ov_o[0]), 32'(tbl[i].ovf));
      check("tbl_unf", i, 32'(un_o[0]), 32'(tbl[i].unf));
    end

    // Circular overflow: pushing 5 onto a full stack drops the oldest entry.
    cyc(0, 0, 0, 1, 16'h0, 100);
    for (int v = 1; v <= 5; v++) cyc(1, 0, 0, 0, 16'(v), 100 + v);
    chk1("wrap_push5", 1, 16'h0005, 16'h0004, 4, 1);
    chk1("sat_push5", 0, 16'h0004, 16'h0003, 4, 1);
    cyc(0, 1, 0, 0, 16'h0, 110);
    chk1("wrap_pop1", 1, 16'h0004, 16'h0003, 3, 1);
    cyc(0, 1, 0, 0, 16'h0, 111);
    chk1("wrap_pop2", 1, 16'h0003, 16'h0002, 2, 1);
    cyc(0, 1, 0, 0, 16'h0, 112);
    chk1("wrap_pop3", 1, 16'h0002, 16'h0000, 1, 1);
    cyc(0, 1, 0, 0, 16'h0, 113);
    chk1("wrap_pop4", 1, 16'h0000, 16'h0000, 0, 1);
    check("wrap_pop4_empty", 1, 32'(e_o[1]), 32'h1);
    // Circular underflow moves the pointer but keeps depth at 0.
    cyc(0, 1, 0, 0, 16'h0, 114);
    check("wrap_unf", 1, 32'(un_o[1]), 32'h1);
    cyc(1, 0, 0, 0, 16'h5A5A, 115);
    chk1("wrap_after_unf", 1, 16'h5A5A, 16'h0000, 1, 1);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 45,
          $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8,
          16'($urandom), 1000 + i);
    end

    // Asynchronous reset mid-cycle after filling three entries.
    cyc(0, 0, 0, 1, 16'h0, 2000);
    while (cnt[0] != 0 || cnt[1] != 0) cyc(0, 1, 0, 0, 16'h0, 2001);
    cyc(0, 1, 0, 0, 16'h0, 2002);
    cyc(1, 0, 0, 0, 16'h0101, 2003);
    cyc(1, 0, 0, 0, 16'h0202, 2004);
    cyc(1, 0, 0, 0, 16'h0303, 2005);
    check("pre_rst_depth", 0, 32'(d_o[0]), 32'h3);
    check("pre_rst_unf", 0, 32'(un_o[0]), 32'h1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      check("arst_T", k, 32'(t_o[k]), 32'h0);
      check("arst_N", k, 32'(n_o[k]), 32'h0);
      check("arst_depth", k, 32'(d_o[k]), 32'h0);
      check("arst_empty", k, 32'(e_o[k]), 32'h1);
      check("arst_ovf", k, 32'(ov_o[k]), 32'h0);
      check("arst_unf", k, 32'(un_o[k]), 32'h0);
    end
    // A push presented while reset is held must have no effect.
    cyc(1, 0, 0, 0, 16'hDEAD, 2010);
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 16'h0042, 2011);
    for (int k = 0; k < 2; k++) chk1("post_rst", k, 16'h0042, 16'h0000, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcpu_stack.md
# dcpu_stack

Parametrised hardware stack for the next-generation dcpu core. It serves as both the data stack and the return stack. Compared with the current fixed-size, unchecked stacks, it adds:
- configurable width and depth;
- a depth counter with full and empty status;
- sticky overflow and underflow error flags;
- a single-cycle replace operation;
- a selectable saturating or circular (wrap-around) mode.

## Interface

Parameters:
- WIDTH, 16, bit width of each entry.
- DEPTH_LOG2, 6, log2 of the number of entries (DEPTH = 2**DEPTH_LOG2).
- WRAP, 0, overflow/underflow mode. 0 = saturating: an offending operation is dropped. 1 = circular: the pointer wraps.

Ports:
- i_clk  in  1  clock. Everything is clocked on the rising edge.
- i_reset_n  in  1  reset, asynchronous and active-low.
- i_push  in  1  push i_dat.
- i_pop  in  1  pop the top entry.
- i_wr_top  in  1  overwrite the top entry with i_dat, depth unchanged.
- i_dat  in  WIDTH  write data.
- i_clr_err  in  1  clear the sticky error flags.
- o_T  out  WIDTH  top entry; 0 when empty.
- o_N  out  WIDTH  second entry; 0 when depth < 2.
- o_depth  out  DEPTH_LOG2+1  number of valid entries, 0..DEPTH.
- o_empty  out  1  o_depth == 0.
- o_full  out  1  o_depth == DEPTH.
- o_overflow  out  1  sticky: a push was attempted while full.
- o_underflow  out  1  sticky: a pop was attempted while empty.

## Operation

State:
- Pointer p (DEPTH_LOG2 bits) indexes the top entry.
- Depth counter d (DEPTH_LOG2+1 bits).
- Storage array of DEPTH entries, not reset.

Command decode, evaluated each cycle:
- push & pop: replace. Write i_dat at p. p and d unchanged. No error, even when empty. If empty, d becomes 1 and p is unchanged.
- push only:
  - p <= p+1 (mod DEPTH), write i_dat at p+1, d <= d+1.
  - If full and WRAP=0: no write, p and d unchanged, o_overflow set.
  - If full and WRAP=1: p wraps, the oldest entry is overwritten, d stays DEPTH, o_overflow set.
- pop only:
  - p <= p-1 (mod DEPTH), d <= d-1.
  - If empty and WRAP=0: nothing changes except o_underflow set.
  - If empty and WRAP=1: p <= p-1, d stays 0, o_underflow set.
- wr_top only: write i_dat at p. If empty, behaves as a push (d becomes 1).
- i_wr_top is ignored whenever i_push or i_pop is asserted.
- No command: hold.

Outputs and flags:
- o_T = mem[p] masked to 0 when d==0.
- o_N = mem[p-1] masked to 0 when d<2.
- Sticky flags are cleared by i_clr_err. A set event in the same cycle wins over the clear.

## Timing

- Reset (asynchronous assert, applies immediately):
  - p = DEPTH-1; d = 0; flags = 0.
  - o_T = o_N = 0, o_empty = 1, o_full = 0.
  - Storage contents are undefined but masked by d.
- Reset release is synchronous to i_clk; the first command is accepted on the first rising edge after release.
- Reset asserted mid-operation aborts any write in that cycle.
- Commands are sampled on the rising edge. The new state and outputs are visible after that edge, so the write-to-read latency is 1 cycle.
- o_T, o_N and status are combinational from registered state only; there is no input-to-output combinational path.
- Back-to-back commands are supported every cycle with no stall and no handshake.
- Arithmetic on p is modulo DEPTH. d never exceeds DEPTH and never goes below 0.

## Test plan

All scenarios use WIDTH=16 and DEPTH_LOG2=2 (DEPTH=4) unless stated.

1. Reset, then push 0x1111 and 0x2222:
   - o_T=0x2222, o_N=0x1111, o_depth=2, o_empty=0.
   - Pop -> o_T=0x1111, o_N=0.
2. Push 1,2,3,4 so o_full=1, then push 5 with WRAP=0:
   - o_overflow=1, o_T=4, o_depth=4.
   - Pop four times -> o_T sequence 3,2,1, then 0 with o_empty=1.
3. Same as 2 with WRAP=1:
   - After pushing 5: o_T=5, o_N=4, o_depth=4, o_overflow=1.
   - Four pops return o_T = 4,3,2 then 0. The entry holding 1 has been overwritten by 5.
4. Pop while empty (WRAP=0): o_underflow=1, o_depth=0.
   - i_clr_err alone -> flag 0.
   - i_clr_err together with another empty pop -> flag stays 1.
5. With depth 2 (0xAAAA, 0xBBBB), assert push & pop with i_dat=0xCCCC:
   - o_T=0xCCCC, o_N=0xAAAA, o_depth=2.
   - Then i_wr_top=1 with i_dat=0x1234 -> o_T=0x1234.
6. Push 3 entries, then assert i_reset_n=0 between clock edges:
   - o_depth=0, o_T=0, flags 0 immediately, without waiting for a clock edge.
   - After release, push 0x0042 -> o_T=0x0042, o_depth=1.
